// File: rtl/wrn_mqueue_pkg.sv
// Shared types and constants for the mqueue UDP receive path.
package wrn_mqueue_pkg;

    localparam int unsigned C_DATA_W    = 32;
    localparam int unsigned C_WORD_W    = 16;
    localparam int unsigned C_HDR_CNT_W = 5;

    // Header word offsets (16-bit words from the start of the Ethernet frame)
    localparam int unsigned C_OFS_SRC_MAC_0  = 3;
    localparam int unsigned C_OFS_SRC_MAC_1  = 4;
    localparam int unsigned C_OFS_SRC_MAC_2  = 5;
    localparam int unsigned C_OFS_ETHERTYPE  = 6;
    localparam int unsigned C_OFS_VER_IHL    = 7;
    localparam int unsigned C_OFS_TTL_PROTO  = 11;
    localparam int unsigned C_OFS_SRC_IP_HI  = 13;
    localparam int unsigned C_OFS_SRC_IP_LO  = 14;
    localparam int unsigned C_OFS_DST_IP_HI  = 15;
    localparam int unsigned C_OFS_DST_IP_LO  = 16;
    localparam int unsigned C_OFS_UDP_SPORT  = 17;
    localparam int unsigned C_OFS_UDP_DPORT  = 18;
    localparam int unsigned C_OFS_UDP_LEN    = 19;
    localparam int unsigned C_OFS_UDP_CSUM   = 20;

    localparam logic [15:0] C_ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  C_IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  C_IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] C_UDP_HDR_BYTES  = 16'd8;
    localparam logic [15:0] C_UDP_MIN_LEN    = 16'd10;
    localparam logic [31:0] C_IP_WILDCARD    = 32'hffff_ffff;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } t_rx_state;

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [C_DATA_W-1:0] data;
    } t_mt_stream_sink_in;

    typedef struct packed {
        logic ready;
    } t_mt_stream_sink_out;

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [C_DATA_W-1:0] data;
    } t_mt_stream_source_out;

    typedef struct packed {
        logic ready;
    } t_mt_stream_source_in;

    // Payload length in 16-bit words; an odd byte count rounds up.
    function automatic logic [15:0] f_payload_words(input logic [15:0] udp_len);
        return 16'(((udp_len - C_UDP_HDR_BYTES) + 16'd1) >> 1);
    endfunction

endpackage

// File: rtl/mt_rmq_rx_udp_deframer.sv
// Strips Ethernet/IPv4/UDP headers from a 16-bit word stream and forwards
// the payload of frames addressed to the configured port/IP.
module mt_rmq_rx_udp_deframer
    import wrn_mqueue_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  t_mt_stream_sink_in    snk_i,
    output t_mt_stream_sink_out   snk_o,
    output t_mt_stream_source_out src_o,
    input  t_mt_stream_source_in  src_i,
    input  logic [15:0]           p_dst_port_i,
    input  logic [31:0]           p_dst_ip_i,
    output logic                  p_header_valid_o,
    output logic [47:0]           p_src_mac_o,
    output logic [31:0]           p_src_ip_o,
    output logic [15:0]           p_src_port_o,
    output logic [15:0]           p_payload_words_o,
    output logic                  p_drop_o,
    output logic                  p_trunc_o
);

    t_rx_state                r_state;
    t_rx_state                w_state_nxt;
    logic [C_HDR_CNT_W-1:0]   r_hdr_cnt;
    logic [15:0]              r_pay_num;

    // Header fields captured while the frame streams in
    logic [47:0]              r_cap_src_mac;
    logic [15:0]              r_cap_ethertype;
    logic [7:0]               r_cap_ver_ihl;
    logic [7:0]               r_cap_proto;
    logic [31:0]              r_cap_src_ip;
    logic [31:0]              r_cap_dst_ip;
    logic [15:0]              r_cap_src_port;
    logic [15:0]              r_cap_dst_port;
    logic [15:0]              r_cap_udp_len;

    // Output register and published fields
    logic                     r_src_valid;
    logic                     r_src_last;
    logic [C_WORD_W-1:0]      r_src_word;
    logic                     r_hdr_valid;
    logic                     r_drop;
    logic                     r_trunc;
    logic [47:0]              r_src_mac;
    logic [31:0]              r_src_ip;
    logic [15:0]              r_src_port;
    logic [15:0]              r_payload_words;

    logic                     w_snk_ready;
    logic                     w_snk_acc;
    logic                     w_hdr_end;
    logic                     w_match;
    logic [15:0]              w_pay_next;
    logic                     w_pay_end;
    logic                     w_hdr_accept;
    logic                     w_hdr_reject;
    logic                     w_pay_load;
    logic                     w_pay_last;
    logic                     w_trunc;
    logic                     w_unused_data;

    // Sink is free in HEADER/DROP; in PAYLOAD it waits for the output slot
    assign w_snk_ready = rst_n_i & ((r_state != ST_PAYLOAD) | ~r_src_valid | src_i.ready);
    assign w_snk_acc   = snk_i.valid & w_snk_ready;
    assign w_hdr_end   = (r_hdr_cnt == C_HDR_CNT_W'(C_OFS_UDP_CSUM));
    assign w_pay_next  = r_pay_num + 16'd1;
    assign w_pay_end   = (w_pay_next == r_payload_words);
    assign w_unused_data = ^snk_i.data[C_DATA_W-1:C_WORD_W];

    assign w_match = (r_cap_ethertype == C_ETHERTYPE_IPV4)
                   & (r_cap_ver_ihl   == C_IP_VER_IHL)
                   & (r_cap_proto     == C_IP_PROTO_UDP)
                   & (r_cap_dst_port  == p_dst_port_i)
                   & ((r_cap_dst_ip == p_dst_ip_i) | (p_dst_ip_i == C_IP_WILDCARD))
                   & (r_cap_udp_len  >= C_UDP_MIN_LEN);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_HEADER;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HEADER: begin
                if (w_snk_acc && !snk_i.last && w_hdr_end) begin
                    w_state_nxt = w_match ? ST_PAYLOAD : ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (w_snk_acc) begin
                    if (snk_i.last) begin
                        w_state_nxt = ST_HEADER;
                    end else if (w_pay_end) begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_snk_acc && snk_i.last) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            default: w_state_nxt = ST_HEADER;
        endcase
    end

    // Per-state event decode feeding the registered outputs
    always_comb begin
        w_hdr_accept = 1'b0;
        w_hdr_reject = 1'b0;
        w_pay_load   = 1'b0;
        w_pay_last   = 1'b0;
        w_trunc      = 1'b0;
        case (r_state)
            ST_HEADER: begin
                if (w_snk_acc) begin
                    if (snk_i.last) begin
                        w_hdr_reject = 1'b1;
                    end else if (w_hdr_end) begin
                        w_hdr_accept = w_match;
                        w_hdr_reject = ~w_match;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_snk_acc) begin
                    w_pay_load = 1'b1;
                    w_pay_last = snk_i.last | w_pay_end;
                    w_trunc    = snk_i.last & ~w_pay_end;
                end
            end
            default: ;
        endcase
    end

    // Header word counter and field capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hdr_cnt       <= '0;
            r_cap_src_mac   <= '0;
            r_cap_ethertype <= '0;
            r_cap_ver_ihl   <= '0;
            r_cap_proto     <= '0;
            r_cap_src_ip    <= '0;
            r_cap_dst_ip    <= '0;
            r_cap_src_port  <= '0;
            r_cap_dst_port  <= '0;
            r_cap_udp_len   <= '0;
        end else if (w_snk_acc && (r_state == ST_HEADER)) begin
            if (snk_i.last || w_hdr_end) begin
                r_hdr_cnt <= '0;
            end else begin
                r_hdr_cnt <= r_hdr_cnt + C_HDR_CNT_W'(1);
            end
            case (r_hdr_cnt)
                C_HDR_CNT_W'(C_OFS_SRC_MAC_0): r_cap_src_mac[47:32] <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_SRC_MAC_1): r_cap_src_mac[31:16] <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_SRC_MAC_2): r_cap_src_mac[15:0]  <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_ETHERTYPE): r_cap_ethertype      <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_VER_IHL):   r_cap_ver_ihl        <= snk_i.data[15:8];
                C_HDR_CNT_W'(C_OFS_TTL_PROTO): r_cap_proto          <= snk_i.data[7:0];
                C_HDR_CNT_W'(C_OFS_SRC_IP_HI): r_cap_src_ip[31:16]  <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_SRC_IP_LO): r_cap_src_ip[15:0]   <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_DST_IP_HI): r_cap_dst_ip[31:16]  <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_DST_IP_LO): r_cap_dst_ip[15:0]   <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_UDP_SPORT): r_cap_src_port       <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_UDP_DPORT): r_cap_dst_port       <= snk_i.data[15:0];
                C_HDR_CNT_W'(C_OFS_UDP_LEN):   r_cap_udp_len        <= snk_i.data[15:0];
                default: ;
            endcase
        end
    end

    // Single-slot payload output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_src_valid <= 1'b0;
            r_src_last  <= 1'b0;
            r_src_word  <= '0;
        end else if (w_pay_load) begin
            r_src_valid <= 1'b1;
            r_src_last  <= w_pay_last;
            r_src_word  <= snk_i.data[C_WORD_W-1:0];
        end else if (r_src_valid && src_i.ready) begin
            r_src_valid <= 1'b0;
            r_src_last  <= 1'b0;
        end
    end

    // Payload word number within the current frame
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pay_num <= '0;
        end else if (w_hdr_accept) begin
            r_pay_num <= '0;
        end else if (w_pay_load) begin
            r_pay_num <= w_pay_next;
        end
    end

    // Status pulses and fields published on header accept
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hdr_valid     <= 1'b0;
            r_drop          <= 1'b0;
            r_trunc         <= 1'b0;
            r_src_mac       <= '0;
            r_src_ip        <= '0;
            r_src_port      <= '0;
            r_payload_words <= '0;
        end else begin
            r_hdr_valid <= w_hdr_accept;
            r_drop      <= w_hdr_reject;
            r_trunc     <= w_trunc;
            if (w_hdr_accept) begin
                r_src_mac       <= r_cap_src_mac;
                r_src_ip        <= r_cap_src_ip;
                r_src_port      <= r_cap_src_port;
                r_payload_words <= f_payload_words(r_cap_udp_len);
            end
        end
    end

    assign snk_o.ready       = w_snk_ready;
    assign src_o.valid       = r_src_valid;
    assign src_o.last        = r_src_last;
    assign src_o.data        = {(C_DATA_W - C_WORD_W)'(0), r_src_word};
    assign p_header_valid_o  = r_hdr_valid;
    assign p_drop_o          = r_drop;
    assign p_trunc_o         = r_trunc;
    assign p_src_mac_o       = r_src_mac;
    assign p_src_ip_o        = r_src_ip;
    assign p_src_port_o      = r_src_port;
    assign p_payload_words_o = r_payload_words;

endmodule

// File: tb/tb_mt_rmq_rx_udp_deframer.sv
// Directed and throttled frame tests for the UDP deframer.
module tb_mt_rmq_rx_udp_deframer;
    import wrn_mqueue_pkg::*;

    logic                  clk_i;
    logic                  rst_n_i;
    t_mt_stream_sink_in    snk_in;
    t_mt_stream_sink_out   snk_out;
    t_mt_stream_source_out src_out;
    t_mt_stream_source_in  src_in;
    logic [15:0]           dst_port;
    logic [31:0]           dst_ip;
    logic                  hdr_valid;
    logic [47:0]           src_mac;
    logic [31:0]           src_ip;
    logic [15:0]           src_port;
    logic [15:0]           payload_words;
    logic                  drop;
    logic                  trunc;

    int n_vec = 0;
    int n_err = 0;
    int n_hv, n_drop, n_trunc;
    bit thr_snk = 0;
    bit thr_src = 0;
    logic [15:0] fr_q[$];
    logic [31:0] mon_data[$];
    logic        mon_last[$];
    bit          prev_stall = 0;
    logic [33:0] prev_word;

    mt_rmq_rx_udp_deframer u_dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .snk_i             (snk_in),
        .snk_o             (snk_out),
        .src_o             (src_out),
        .src_i             (src_in),
        .p_dst_port_i      (dst_port),
        .p_dst_ip_i        (dst_ip),
        .p_header_valid_o  (hdr_valid),
        .p_src_mac_o       (src_mac),
        .p_src_ip_o        (src_ip),
        .p_src_port_o      (src_port),
        .p_payload_words_o (payload_words),
        .p_drop_o          (drop),
        .p_trunc_o         (trunc)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Source-side throttle
    always @(negedge clk_i) begin
        src_in.ready = thr_src ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: collects words, counts pulses, checks hold under stall
    always @(negedge clk_i) begin
        #2;
        if (!rst_n_i) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("hold", 64'({src_out.valid, src_out.last, src_out.data}), 64'(prev_word));
            if (hdr_valid) n_hv++;
            if (drop)      n_drop++;
            if (trunc)     n_trunc++;
            if (src_out.valid && src_in.ready) begin
                mon_data.push_back(src_out.data);
                mon_last.push_back(src_out.last);
            end
            prev_stall = src_out.valid && !src_in.ready;
            prev_word  = {src_out.valid, src_out.last, src_out.data};
        end
    end

    function automatic void build_frame(input logic [15:0] etype, input logic [15:0] dport,
                                        input logic [15:0] len, input logic [15:0] dip_lo,
                                        input int npay, input int npad, input logic [15:0] base);
        logic [15:0] hdr[21];
        hdr = '{16'h0011, 16'h2233, 16'h4455, 16'ha1a2, 16'ha3a4, 16'ha5a6, etype,
                16'h4500, 16'h0000, 16'h0000, 16'h0000, 16'h4011, 16'h0000,
                16'hc0a8, 16'h0001, 16'hc0a8, dip_lo, 16'h1f90, dport, len, 16'h0000};
        fr_q.delete();
        for (int i = 0; i < 21; i++) fr_q.push_back(hdr[i]);
        for (int i = 0; i < npay; i++) fr_q.push_back(base + 16'(i));
        for (int i = 0; i < npad; i++) fr_q.push_back(16'hdead);
    endfunction

    // Drive fr_q; stops after n_stop accepted words when n_stop >= 0
    task automatic drive_words(input int n_stop);
        int n = fr_q.size();
        for (int i = 0; i < n; i++) begin
            int  tmo  = 0;
            bit  done = 0;
            if (n_stop >= 0 && i >= n_stop) break;
            while (!done) begin
                @(negedge clk_i);
                snk_in.valid = thr_snk ? 1'($urandom_range(0, 1)) : 1'b1;
                snk_in.data  = {16'hbeef, fr_q[i]};
                snk_in.last  = (i == n - 1);
                #1;
                if (snk_in.valid && snk_out.ready) done = 1;
                else if (++tmo > 200) begin
                    chk("snk_timeout", 64'(0), 64'(1));
                    snk_in.valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk_i);
        snk_in.valid = 1'b0;
        snk_in.last  = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk_i);
        #3;
        mon_data.delete();
        mon_last.delete();
        n_hv = 0; n_drop = 0; n_trunc = 0;
    endtask

    task automatic drain();
        bit idle = 0;
        repeat (2) @(negedge clk_i);
        for (int t = 0; t < 300 && !idle; t++) begin
            @(negedge clk_i);
            #3;
            if (!src_out.valid) idle = 1;
        end
        if (!idle) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_frame(input logic [15:0] etype, input logic [15:0] dport,
                             input logic [15:0] len, input logic [15:0] dip_lo,
                             input int npay, input int npad, input logic [15:0] base);
        clear_mon();
        build_frame(etype, dport, len, dip_lo, npay, npad, base);
        drive_words(-1);
        drain();
    endtask

    task automatic check_rx(input string tag, input int e_hv, input int e_drop, input int e_trunc,
                            input int e_n, input logic [15:0] base);
        chk({tag, "_hv"},    64'(n_hv),    64'(e_hv));
        chk({tag, "_drop"},  64'(n_drop),  64'(e_drop));
        chk({tag, "_trunc"}, 64'(n_trunc), 64'(e_trunc));
        chk({tag, "_nwords"}, 64'(mon_data.size()), 64'(e_n));
        for (int i = 0; i < mon_data.size() && i < e_n; i++) begin
            logic [15:0] w;
            w = base + 16'(i);
            chk({tag, "_data"}, 64'(mon_data[i]), 64'({16'h0000, w}));
            chk({tag, "_last"}, 64'(mon_last[i]), 64'(i == e_n - 1));
        end
    endtask

    initial begin
        rst_n_i  = 1'b0;
        snk_in   = '0;
        src_in   = '0;
        dst_port = 16'hebd1;
        dst_ip   = 32'hffff_ffff;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_src_valid", 64'(src_out.valid), 64'(0));
        chk("rst_snk_ready", 64'(snk_out.ready), 64'(0));
        chk("rst_pwords",    64'(payload_words), 64'(0));
        chk("rst_src_mac",   64'(src_mac),       64'(0));
        chk("rst_hv",        64'(hdr_valid),     64'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("post_rst_ready", 64'(snk_out.ready), 64'(1));

        // Basic valid frame: len 40 -> 16 words
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0000);
        check_rx("basic", 1, 0, 0, 16, 16'h0000);
        chk("basic_pwords", 64'(payload_words), 64'(16));
        chk("basic_mac",    64'(src_mac),  64'(48'ha1a2a3a4a5a6));
        chk("basic_ip",     64'(src_ip),   64'(32'hc0a80001));
        chk("basic_port",   64'(src_port), 64'(16'h1f90));

        // Odd length 41 -> 17 words, 4 padding words discarded
        run_frame(16'h0800, 16'hebd1, 16'd41, 16'h0002, 17, 4, 16'h0000);
        check_rx("odd", 1, 0, 0, 17, 16'h0000);
        chk("odd_pwords", 64'(payload_words), 64'(17));

        // Wrong port dropped, fields held, next frame accepted
        run_frame(16'h0800, 16'h1234, 16'd40, 16'h0002, 16, 0, 16'h0000);
        check_rx("badport", 0, 1, 0, 0, 16'h0000);
        chk("badport_pwords_held", 64'(payload_words), 64'(17));
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0100);
        check_rx("after_drop", 1, 0, 0, 16, 16'h0100);

        // Specific destination IP
        dst_ip = 32'hc0a8_0002;
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0300);
        check_rx("ip_match", 1, 0, 0, 16, 16'h0300);
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0003, 16, 0, 16'h0300);
        check_rx("ip_miss", 0, 1, 0, 0, 16'h0000);
        dst_ip = 32'hffff_ffff;

        // UDP length limits and bad ethertype
        run_frame(16'h0800, 16'hebd1, 16'd9, 16'h0002, 1, 0, 16'h0000);
        check_rx("len9", 0, 1, 0, 0, 16'h0000);
        run_frame(16'h0800, 16'hebd1, 16'd10, 16'h0002, 1, 0, 16'h0400);
        check_rx("len10", 1, 0, 0, 1, 16'h0400);
        chk("len10_pwords", 64'(payload_words), 64'(1));
        run_frame(16'h86dd, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0000);
        check_rx("etype", 0, 1, 0, 0, 16'h0000);

        // Truncated payload: last on word 10 of 16
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 10, 0, 16'h0200);
        check_rx("trunc", 1, 0, 1, 10, 16'h0200);

        // Frame ending inside the header
        clear_mon();
        build_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0000);
        fr_q = fr_q[0:4];
        drive_words(-1);
        drain();
        check_rx("short_hdr", 0, 1, 0, 0, 16'h0000);
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0500);
        check_rx("after_short", 1, 0, 0, 16, 16'h0500);

        // Reset in the middle of the payload
        clear_mon();
        build_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0600);
        drive_words(26);
        chk("pre_rst_valid", 64'(src_out.valid), 64'(1));
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid",  64'(src_out.valid), 64'(0));
        chk("mid_rst_last",   64'(src_out.last),  64'(0));
        chk("mid_rst_ready",  64'(snk_out.ready), 64'(0));
        chk("mid_rst_pwords", 64'(payload_words), 64'(0));
        chk("mid_rst_port",   64'(src_port),      64'(0));
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        run_frame(16'h0800, 16'hebd1, 16'd40, 16'h0002, 16, 0, 16'h0700);
        check_rx("after_rst", 1, 0, 0, 16, 16'h0700);
        chk("after_rst_pwords", 64'(payload_words), 64'(16));

        // Throttled source and sink over many frames
        thr_snk = 1;
        thr_src = 1;
        for (int k = 0; k < 100; k++) begin
            logic [15:0] len;
            int          n;
            len = 16'(10 + (k * 7) % 37);
            n   = int'((len - 16'd7) >> 1);
            run_frame(16'h0800, 16'hebd1, len, 16'h0002, n, k % 4, 16'(k * 256));
            check_rx("rnd", 1, 0, 0, n, 16'(k * 256));
        end
        thr_snk = 0;
        thr_src = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
